// File: rtl/lfsr_countdown_ctrl.sv
// Run controller for an external countdown: holds it in reset while arming,
// enables it while running, counts expiries and supports pause, abort and periodic re-arm.
module lfsr_countdown_ctrl #(
  parameter int unsigned CLR_CYCLES = 3,
  parameter int unsigned EXP_W      = 16
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_start,
  output logic             o_ready,
  input  logic             i_repeat,
  input  logic             i_pause,
  input  logic             i_abort,
  output logic             o_cd_reset,
  output logic             o_cd_enable,
  input  logic             i_cd_done,
  output logic             o_busy,
  output logic             o_tick,
  output logic [EXP_W-1:0] o_exp_count,
  output logic             o_overrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    PAUSE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [7:0] CLR_LOAD = 8'(CLR_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [7:0]       clr_cnt_reg, clr_cnt_next;
  logic             repeat_reg, repeat_next;
  logic             done_hit;

  logic             cd_reset_reg;
  logic             cd_enable_reg;
  logic             ready_reg;
  logic             busy_reg;
  logic             tick_reg;
  logic             overrun_reg;
  logic [EXP_W-1:0] exp_cnt_reg;

  // Next-state logic; abort outranks everything except reset.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    repeat_next  = repeat_reg;
    done_hit     = 1'b0;
    if (i_abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start && ready_reg) begin
            state_next   = CLEAR;
            repeat_next  = i_repeat;
            clr_cnt_next = CLR_LOAD;
          end
        end
        CLEAR: begin
          // A done still high here is left over from the previous run; wait it out.
          if (clr_cnt_reg != 8'd0) begin
            clr_cnt_next = clr_cnt_reg - 8'd1;
          end else if (!i_cd_done) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (i_cd_done) begin
            done_hit = 1'b1;
          end else if (i_pause) begin
            state_next = PAUSE;
          end
        end
        PAUSE: begin
          if (i_cd_done) begin
            done_hit = 1'b1;
          end else if (!i_pause) begin
            state_next = RUN;
          end
        end
        FINISH: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
      if (done_hit) begin
        if (repeat_reg) begin
          state_next   = CLEAR;
          clr_cnt_next = CLR_LOAD;
        end else begin
          state_next = FINISH;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they change together with it.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_reg     <= IDLE;
      clr_cnt_reg   <= 8'd0;
      repeat_reg    <= 1'b0;
      cd_reset_reg  <= 1'b1;
      cd_enable_reg <= 1'b0;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      tick_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
      exp_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      clr_cnt_reg   <= clr_cnt_next;
      repeat_reg    <= repeat_next;
      cd_reset_reg  <= (state_next == IDLE) || (state_next == CLEAR) ||
                       (state_next == FINISH);
      cd_enable_reg <= (state_next == RUN);
      ready_reg     <= (state_next == IDLE);
      busy_reg      <= (state_next != IDLE);
      tick_reg      <= done_hit;
      overrun_reg   <= i_start && !ready_reg;
      if (done_hit && (exp_cnt_reg != '1)) begin
        exp_cnt_reg <= exp_cnt_reg + EXP_W'(1);
      end
    end
  end

  assign o_cd_reset  = cd_reset_reg;
  assign o_cd_enable = cd_enable_reg;
  assign o_ready     = ready_reg;
  assign o_busy      = busy_reg;
  assign o_tick      = tick_reg;
  assign o_overrun   = overrun_reg;
  assign o_exp_count = exp_cnt_reg;

endmodule

// File: doc/lfsr_countdown_ctrl.md
LFSR_COUNTDOWN_CTRL -- requirements
Module: lfsr_countdown_ctrl

Interface
REQ-001 Parameter CLR_CYCLES, default 3: number of cycles the countdown reset is held after a start or re-arm (range 1..255).
REQ-002 Parameter EXP_W, default 16: width of the expiry counter.
REQ-003 Port clock, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port i_reset, input, 1: synchronous, active-high reset.
REQ-005 Port i_start, input, 1: start request, valid-style; accepted when i_start and o_ready are both high in one cycle.
REQ-006 Port o_ready, output, 1: the controller can accept a start.
REQ-007 Port i_repeat, input, 1: periodic mode; sampled at start acceptance only.
REQ-008 Port i_pause, input, 1: level; freezes the countdown while high.
REQ-009 Port i_abort, input, 1: level; terminates any run.
REQ-010 Port o_cd_reset, output, 1: drives the countdown's i_reset.
REQ-011 Port o_cd_enable, output, 1: drives the countdown's i_enable.
REQ-012 Port i_cd_done, input, 1: the countdown's o_done; treated as a level.
REQ-013 Port o_busy, output, 1: a run is in progress (any state other than IDLE).
REQ-014 Port o_tick, output, 1: one-cycle pulse per countdown expiry.
REQ-015 Port o_exp_count, output, EXP_W: number of expiries since reset; saturates.
REQ-016 Port o_overrun, output, 1: one-cycle pulse when i_start is high and o_ready is low.

Function
REQ-017 The FSM SHALL have the states IDLE, CLEAR, RUN, PAUSE and FINISH; all outputs SHALL be registered.
REQ-018 IDLE: o_cd_reset=1, o_cd_enable=0, o_ready=1; an accepted start SHALL latch i_repeat, load the clear counter with CLR_CYCLES-1, and move to CLEAR.
REQ-019 CLEAR: o_cd_reset=1, o_cd_enable=0; the counter SHALL decrement each cycle; when it is 0 and i_cd_done=0, the FSM SHALL move to RUN; while i_cd_done=1 it SHALL stay in CLEAR (countdown pipeline flush).
REQ-020 RUN: o_cd_reset=0, o_cd_enable=1; i_pause=1 SHALL move to PAUSE and drop o_cd_enable in the same cycle as the state change.
REQ-021 PAUSE: o_cd_reset=0, o_cd_enable=0; i_pause=0 SHALL return to RUN.
REQ-022 In RUN or PAUSE, i_cd_done=1 SHALL pulse o_tick for exactly one cycle and increment o_exp_count (saturating at 2^EXP_W-1); if done and pause occur together, done SHALL take priority.
REQ-023 On done with repeat latched, the FSM SHALL go to CLEAR (re-arm, with reload of CLR_CYCLES-1); on done without repeat, it SHALL go to FINISH.
REQ-024 FINISH: o_cd_reset=1, o_cd_enable=0, o_ready=0; the FSM SHALL return to IDLE on the next cycle.
REQ-025 i_abort=1 SHALL force IDLE from any state on the next edge, without a tick, and SHALL take priority over done, pause and start; a start in the same cycle as an abort SHALL NOT be accepted.
REQ-026 o_overrun SHALL pulse for each cycle with i_start=1 and o_ready=0; such a start SHALL be dropped, not queued.
REQ-027 o_exp_count SHALL be cleared only by i_reset; it SHALL NOT be cleared by start or abort.

Reset
REQ-028 When i_reset=1, the block SHALL enter IDLE and set o_cd_reset=1, o_cd_enable=0, o_ready=1, o_busy=0, o_tick=0, o_overrun=0, o_exp_count=0, and clear the latched repeat flag.
REQ-029 Reset mid-run SHALL take effect on the next edge, overriding all other inputs.

Verification
REQ-030 Single shot: CLR_CYCLES=3, mock countdown with done 10 enabled cycles after its reset is released; start with repeat=0 -> o_cd_enable high 3 cycles after acceptance, o_tick once, o_exp_count=1, then IDLE with o_ready=1.
REQ-031 Repeat mode: start with repeat=1, run 4 expiries -> 4 o_tick pulses each separated by CLEAR (3+ cycles with o_cd_reset=1), o_exp_count=4, o_busy stays 1.
REQ-032 Pause: pause for 5 cycles mid-run -> o_cd_enable low 5 cycles, tick delayed by exactly 5 cycles versus REQ-030.
REQ-033 Abort and start in the same cycle during RUN -> IDLE next cycle, no tick, start not accepted, o_exp_count unchanged.
REQ-034 Start while busy -> o_overrun pulse per cycle, run unaffected; with EXP_W=2 and 5 repeat expiries -> o_exp_count saturates at 3.
REQ-035 Stale done: i_cd_done held high 2 cycles into CLEAR -> RUN entered only after done is low and the counter has expired.
